// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset controller: opcodes,
// state and instruction-class encodings, and datapath select encodings.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_LUI
  } instr_class_e;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10} wb_sel_e;
  typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_BRANCH = 2'b01, PC_JUMP = 2'b10} pc_sel_e;

  // Every instruction-retiring transition parks in IDLE when run has dropped.
  function automatic state_e boundary_target(input logic run);
    return run ? ST_FETCH : ST_IDLE;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared instruction/data memory handshake between the controller and memory.
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, mem_we, addr_sel, input mem_ready);
    modport slave  (input mem_req, mem_we, addr_sel, output mem_ready);
endinterface

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode-to-class mapping; legal is low for unsupported opcodes.
module ctrl_opcode_decode
    import ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e cls,
    output logic         legal
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        cls   = CLS_R;
        legal = 1'b1;
        case (opcode)
            OPC_R:      cls = CLS_R;
            OPC_I:      cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_JAL:    cls = CLS_JAL;
            OPC_LUI:    cls = CLS_LUI;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, memory wait
// timeout and sticky fault. Outputs are decoded from state and registered class.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W     = 2,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [31:0]         instr,
    input  logic                alu_zero,
    multicycle_control_unit_if.master mem,
    output logic                ir_write,
    output logic                reg_write,
    output logic                alu_src,
    output logic                alu_a_zero,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          wb_sel,
    output logic                pc_write,
    output logic [1:0]          pc_sel,
    output logic                instr_done,
    output logic                fault,
    output logic [2:0]          state_dbg
);

    state_e       state, state_next;
    instr_class_e cls_q, dec_cls;
    logic         dec_legal;
    logic [CNT_W-1:0] wait_cnt;
    logic         req_active, waiting, timeout, taken;
    alu_op_e      alu_op_enc;
    logic         unused_instr;

    ctrl_opcode_decode u_decode (
        .opcode (instr[6:0]),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    assign unused_instr = ^{instr[31:13], instr[11:7]};
    assign taken        = alu_zero ^ instr[12];
    // Derived from state rather than mem_req to keep next-state logic loop-free.
    assign req_active   = (state == ST_FETCH) || (state == ST_MEM);
    assign waiting      = req_active && !mem.mem_ready;
    assign timeout      = waiting && (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cls_q    <= CLS_R;
            wait_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (state == ST_DECODE) cls_q <= dec_cls;
            if (state_next != state)  wait_cnt <= '0;
            else if (waiting)         wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src      = 1'b0;
        alu_a_zero   = 1'b0;
        alu_op_enc   = ALU_ADD;
        wb_sel       = WB_ALU;
        pc_write     = 1'b0;
        pc_sel       = PC_PLUS4;
        instr_done   = 1'b0;
        fault        = 1'b0;
        case (state)
            ST_IDLE: if (run) state_next = ST_FETCH;
            ST_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_write   = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_DECODE: state_next = dec_legal ? ST_EXEC : ST_FAULT;
            ST_EXEC: begin
                state_next = ST_WB;
                case (cls_q)
                    CLS_R: alu_op_enc = ALU_FUNCT;
                    CLS_I: begin
                        alu_op_enc = ALU_FUNCT;
                        alu_src    = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src    = 1'b1;
                        state_next = ST_MEM;
                    end
                    CLS_LUI: begin
                        alu_src    = 1'b1;
                        alu_a_zero = 1'b1;
                    end
                    CLS_BRANCH: begin
                        alu_op_enc = ALU_SUB;
                        pc_write   = 1'b1;
                        pc_sel     = taken ? PC_BRANCH : PC_PLUS4;
                        instr_done = 1'b1;
                        state_next = boundary_target(run);
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_we   = (cls_q == CLS_STORE);
                if (mem.mem_ready) begin
                    if (cls_q == CLS_STORE) begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_next = boundary_target(run);
                    end else begin
                        state_next = ST_WB;
                    end
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (cls_q == CLS_LOAD) ? WB_MEM : (cls_q == CLS_JAL) ? WB_PC4 : WB_ALU;
                pc_write   = 1'b1;
                pc_sel     = (cls_q == CLS_JAL) ? PC_JUMP : PC_PLUS4;
                instr_done = 1'b1;
                state_next = boundary_target(run);
            end
            ST_FAULT: fault = 1'b1;
            default:  state_next = ST_FAULT;
        endcase
    end

    assign alu_op    = ALU_OP_W'(alu_op_enc);
    assign state_dbg = state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle RV32I-subset controller. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath enables and selects. It handshakes with a shared instruction/data memory, handles memory stalls with a timeout, and raises a sticky fault on an illegal opcode or a memory timeout. It sits between the instruction register/memory port and the register file/ALU/PC datapath.

Parameters:
ALU_OP_W, 2, width of alu_op; the encodings below use the two LSBs and any upper bits are zero.
MEM_WAIT_MAX, 15, maximum cycles mem_req may stay unacknowledged before FAULT (>=1).
CNT_W, 4, width of the wait counter; must satisfy 2**CNT_W > MEM_WAIT_MAX.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = execute, 0 = halt at the next instruction boundary
instr  in  32  instruction register contents (valid from DECODE onward)
mem_ready  in  1  memory acknowledges mem_req this cycle
alu_zero  in  1  ALU result == 0
mem_req  out  1  memory access request
mem_we  out  1  store when 1 (qualified by mem_req)
addr_sel  out  1  0 = PC, 1 = ALU result
ir_write  out  1  latch read data into the IR
reg_write  out  1  register file write enable
alu_src  out  1  0 = rs2, 1 = immediate
alu_a_zero  out  1  force ALU operand A to 0 (LUI)
alu_op  out  ALU_OP_W  00 = add, 01 = sub/compare, 10 = funct-decoded
wb_sel  out  2  00 = ALU, 01 = memory data, 10 = PC+4
pc_write  out  1  PC update enable
pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target
instr_done  out  1  one-cycle pulse when an instruction retires
fault  out  1  sticky error flag
state_dbg  out  3  current state encoding

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6. Outputs are Moore outputs decoded from the state and a registered instruction class, except where an output is qualified by mem_ready or alu_zero.
- Reset: state goes to IDLE and every output is 0. This also applies when rst_n asserts mid-instruction; the instruction is abandoned and no pulses are emitted.
- IDLE: go to FETCH when run=1.
- FETCH:
  - Outputs: mem_req=1, addr_sel=0.
  - On mem_ready: ir_write=1 in the same cycle, then go to DECODE.
- DECODE:
  - Takes exactly 1 cycle. Register instr[6:0] into a class:
    - R 0110011
    - I 0010011
    - LOAD 0000011
    - STORE 0100011
    - BRANCH 1100011
    - JAL 1101111
    - LUI 0110111
  - Any other opcode goes to FAULT.
- EXEC, per class:
  - R: alu_op=10, alu_src=0.
  - I: alu_op=10, alu_src=1.
  - LOAD and STORE: alu_op=00, alu_src=1.
  - LUI: alu_op=00, alu_src=1, alu_a_zero=1.
  - BRANCH: alu_op=01, alu_src=0.
    - taken = alu_zero XOR instr[12] (BEQ/BNE); other funct3 values are treated as BEQ/BNE by bit 12.
    - Outputs: pc_write=1, pc_sel = taken ? 01 : 00, instr_done=1.
    - Next state: FETCH.
  - JAL: no ALU requirement.
  - Next state: MEM for LOAD/STORE, WB for all other non-BRANCH classes.
- MEM:
  - Outputs: mem_req=1, addr_sel=1, mem_we = (class==STORE).
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE drives pc_write=1, pc_sel=00 and instr_done=1 in that cycle, then goes to FETCH.
- WB:
  - reg_write=1.
  - wb_sel: 01 for LOAD, 10 for JAL, 00 otherwise.
  - pc_write=1 with pc_sel = 10 for JAL, 00 otherwise.
  - instr_done=1.
  - Next state: FETCH.
- Instruction boundary: every transition that targets FETCH goes to IDLE instead when run=0 in that cycle. Deasserting run never aborts an instruction.
- Latency with zero memory wait (mem_ready already high during FETCH/MEM): BRANCH 3 cycles; R, I, LUI, JAL and STORE 4 cycles; LOAD 5 cycles. Each memory wait cycle adds 1.
- Wait counter:
  - Clears on entering FETCH or MEM and increments each cycle mem_req is high without mem_ready.
  - Reaching MEM_WAIT_MAX without mem_ready goes to FAULT on the next edge.
  - mem_ready in the same cycle the count hits the limit wins, and the access completes.
- FAULT: fault=1 and all other enables are 0. The state is held until rst_n; run is ignored.
- While a request is pending, no write enable (reg_write, pc_write) is asserted.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants
  - state encoding
  - instruction-class enum
  - alu_op, wb_sel and pc_sel encodings
- One sub-module, ctrl_opcode_decode: combinational opcode-to-class mapping with a legal flag. The FSM and the wait counter stay in multicycle_control_unit.

Test Plan:
- Reset then run=1, ADDI (0x00500093), mem_ready=1 -> states 1,2,3,5; reg_write=1 and pc_write=1 with pc_sel=00 in WB; instr_done pulses once; 4 cycles total.
- LW (0x0000A103) with 2 wait cycles in MEM -> mem_req with addr_sel=1 and mem_we=0 held 3 cycles; WB shows wb_sel=01; 7 cycles total.
- BEQ (0x00208463): alu_zero=1 gives pc_sel=01 in EXEC; alu_zero=0 gives pc_sel=00; both take 3 cycles with no reg_write.
- Opcode 0x7F -> FAULT after DECODE; fault=1 and all enables 0; toggling run keeps fault; rst_n=0 clears to IDLE.
- mem_ready held 0 in FETCH -> FAULT after MEM_WAIT_MAX=15 cycles; a second run with mem_ready arriving on cycle 15 completes normally.
- run dropped during EXEC of SW -> store completes with instr_done=1, then IDLE; rst_n pulsed mid-MEM -> all outputs 0 immediately (asynchronous).
